// File: rtl/spm_mult_seq.sv
// spm_mult_seq: serial-parallel carry-save multiplier with valid/ready streams.
// x is held in parallel against WIDTH sum/carry cells while y is fed in LSB
// first; one product bit leaves cell 0 per cycle, 2*WIDTH cycles per product.
// Build option: define SPM_SIGNED_EN for a two's-complement multiply
// (y sign-extended serially, inverted MSB partial product plus correction carry).
`timescale 1ns/1ps

module spm_mult_seq #(
    parameter int unsigned WIDTH = 32,
    localparam int unsigned CNT_W = $clog2(2 * WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy
);

    localparam int unsigned P_W = 2 * WIDTH;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P_W - 1);
`ifdef SPM_SIGNED_EN
    localparam logic [WIDTH-1:0] MSB_ONE = {1'b1, (WIDTH-1)'(0)};
`else
    localparam logic [CNT_W-1:0] CNT_Y = CNT_W'(WIDTH);
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              accept;

    logic [WIDTH-1:0]  x_reg;
    logic [WIDTH-1:0]  y_shift;
    logic [WIDTH-1:0]  y_shift_nxt;
    logic [WIDTH-1:0]  sc;
    logic [WIDTH-1:0]  cc;
    logic [WIDTH-1:0]  cc_init;
    logic [P_W-1:0]    p_shift;
    logic [CNT_W-1:0]  counter;

    logic              ys;
    logic [WIDTH-1:0]  pp;
    logic [WIDTH-1:0]  sc_in;
    logic [WIDTH-1:0]  sum;
    logic [WIDTH-1:0]  carry;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, operand acceptance and input ready; clr overrides everything.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        in_ready  = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (counter == CNT_LAST) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                in_ready = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        accept    = 1'b1;
                        state_nxt = S_RUN;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        if (clr) begin
            accept    = 1'b0;
            state_nxt = S_IDLE;
        end
    end

    // Carry-save cell row: serial y bit gates x, cell i+1 sum feeds cell i.
    always_comb begin
`ifdef SPM_SIGNED_EN
        ys          = y_shift[0];
        y_shift_nxt = {y_shift[WIDTH-1], y_shift[WIDTH-1:1]};
        pp          = (x_reg & {WIDTH{ys}}) ^ MSB_ONE;
        cc_init     = MSB_ONE;
`else
        ys          = (counter < CNT_Y) ? y_shift[0] : 1'b0;
        y_shift_nxt = {1'b0, y_shift[WIDTH-1:1]};
        pp          = x_reg & {WIDTH{ys}};
        cc_init     = '0;
`endif
        sc_in = {1'b0, sc[WIDTH-1:1]};
        sum   = pp ^ sc_in ^ cc;
        carry = (pp & sc_in) | (pp & cc) | (sc_in & cc);
    end

    // Datapath: latch operands on accept, step the cell row while running.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_reg   <= '0;
            y_shift <= '0;
            sc      <= '0;
            cc      <= '0;
            p_shift <= '0;
            counter <= '0;
        end else if (clr) begin
            sc      <= '0;
            cc      <= '0;
            p_shift <= '0;
            counter <= '0;
        end else if (accept) begin
            x_reg   <= x;
            y_shift <= y;
            sc      <= '0;
            cc      <= cc_init;
            p_shift <= '0;
            counter <= '0;
        end else if (state == S_RUN) begin
            sc      <= sum;
            cc      <= carry;
            p_shift <= {sum[0], p_shift[P_W-1:1]};
            y_shift <= y_shift_nxt;
            counter <= counter + CNT_W'(1);
        end
    end

    // Status decode; p reads as zero unless a product is being offered.
    always_comb begin
        busy      = (state == S_RUN);
        out_valid = (state == S_DONE);
        p         = out_valid ? p_shift : '0;
    end

endmodule

// File: tb/tb_spm_mult_seq.sv
// Scoreboard bench for spm_mult_seq at WIDTH=8 (unsigned or SPM_SIGNED_EN build).
`timescale 1ns/1ps

module tb_spm_mult_seq;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned P_W   = 2 * WIDTH;

    logic             clk = 1'b0;
    logic             rst;
    logic             clr;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             out_valid;
    logic             out_ready;
    logic [P_W-1:0]   p;
    logic             busy;

    spm_mult_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    int t_acc    = 0;
    logic [P_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [P_W-1:0] act, input logic [P_W-1:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%04h, required 0x%04h", name, act, req);
    endtask

    // Monitor: every product handed over is compared with the oldest expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_product: got 0x%04h, required no product", p);
            end else begin
                logic [P_W-1:0] e;
                e = exp_q.pop_front();
                check("product", p, e);
            end
        end
    end

    // Offer operands until accepted; optionally record the expected product.
    task automatic issue(input logic [WIDTH-1:0] xv, input logic [WIDTH-1:0] yv,
                         input logic [P_W-1:0] pexp, input bit push);
        bit ok;
        ok = 1'b0;
        x = xv;
        y = yv;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check("accept_ready", P_W'(ok), P_W'(1));
        if (ok && push) exp_q.push_back(pexp);
        @(posedge clk);
        #1;
        t_acc    = cyc;
        in_valid = 1'b0;
        x = ~xv;
        y = ~yv;
    endtask

    // Wait for out_valid (bounded), checking latency and busy/in_ready meanwhile.
    task automatic wait_done(input string name);
        bit seen;
        bit bad;
        int lat;
        seen = 1'b0;
        bad  = 1'b0;
        lat  = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                seen = 1'b1;
                lat  = cyc - t_acc;
                break;
            end
            if (busy !== 1'b1 || in_ready !== 1'b0) bad = 1'b1;
        end
        check({name, "_latency"}, P_W'(lat), P_W'(16));
        check({name, "_run_flags"}, P_W'(bad), P_W'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "bench stopped by watchdog");
    end

    initial begin
        bit bad;
        logic [P_W-1:0] e_signed;
        rst = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        x = '0; y = '0;
        #2;
        check("rst_in_ready", P_W'(in_ready), P_W'(1));
        check("rst_out_valid", P_W'(out_valid), P_W'(0));
        check("rst_busy", P_W'(busy), P_W'(0));
        check("rst_p", p, P_W'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        // Basic and corner products.
        issue(8'd13, 8'd11, 16'h008F, 1'b1);
        wait_done("op13x11");
        @(posedge clk); #1;
        issue(8'd255, 8'd255, 16'hFE01, 1'b1);
        wait_done("op255x255");
        @(posedge clk); #1;
        issue(8'd0, 8'hA5, 16'h0000, 1'b1);
        wait_done("op0xA5");
        @(posedge clk); #1;

        // Backpressure for 5 cycles, then back-to-back handover.
        out_ready = 1'b0;
        issue(8'd7, 8'd9, 16'h003F, 1'b1);
        wait_done("op7x9");
        bad = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || p !== 16'h003F) bad = 1'b1;
        end
        check("bp_hold", P_W'(bad), P_W'(0));
        check("bp_p_held", p, 16'h003F);
        out_ready = 1'b1;
        issue(8'd3, 8'd4, 16'h000C, 1'b1);
        wait_done("b2b3x4");
        @(posedge clk); #1;

        // Abort in the middle of a run.
        issue(8'd5, 8'd6, 16'h001E, 1'b0);
        repeat (6) @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        check("clr_busy", P_W'(busy), P_W'(0));
        check("clr_in_ready", P_W'(in_ready), P_W'(1));
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid !== 1'b0) bad = 1'b1;
        end
        check("clr_no_valid", P_W'(bad), P_W'(0));
        @(posedge clk); #1;

        // clr wins over in_valid in IDLE.
        clr = 1'b1; in_valid = 1'b1; x = 8'd1; y = 8'd1;
        @(posedge clk); #1;
        clr = 1'b0; in_valid = 1'b0;
        check("clr_blocks_accept", P_W'(busy), P_W'(0));
        issue(8'd2, 8'd2, 16'h0004, 1'b1);
        wait_done("op2x2");
        @(posedge clk); #1;

        // Asynchronous reset between clock edges while running.
        issue(8'd9, 8'd9, 16'h0051, 1'b0);
        repeat (5) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("arst_busy", P_W'(busy), P_W'(0));
        check("arst_in_ready", P_W'(in_ready), P_W'(1));
        check("arst_out_valid", P_W'(out_valid), P_W'(0));
        check("arst_p", p, P_W'(0));
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        // Build-dependent arithmetic.
`ifdef SPM_SIGNED_EN
        e_signed = 16'hFFF1;
`else
        e_signed = 16'h04F1;
`endif
        issue(8'hFD, 8'd5, e_signed, 1'b1);
        wait_done("opFDx05");
        @(posedge clk); #1;
        issue(8'h80, 8'h80, 16'h4000, 1'b1);
        wait_done("op80x80");
        @(posedge clk); #1;

        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", P_W'(exp_q.size()), P_W'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
